// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter: loader byte writes vs. CPU LSU, with lane steering and load formatting.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_port_arbiter #(
    parameter int ADDR_W      = 12,
    parameter bit LD_PRIORITY = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_wdata,
    output logic              ld_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [2:0]        cpu_funct3,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t      r_state;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_lo;
    logic        r_rd_rsp;
    logic [31:0] r_cpu_rdata;

    logic              w_grant_ld;
    logic              w_grant_cpu;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [1:0]        w_sel_lo;
    logic [1:0]        w_sel_size;
    logic [31:0]       w_sel_data;
    logic              w_sel_store;
    logic              w_misalign;
    logic [3:0]        w_mask;
    logic [31:0]       w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_fmt;

    assign w_grant_ld  = ld_req && (!cpu_req || LD_PRIORITY);
    assign w_grant_cpu = cpu_req && !w_grant_ld;
    assign w_sel_addr  = w_grant_ld ? ld_addr : cpu_addr;
    assign w_sel_lo    = w_sel_addr[1:0];
    assign w_sel_data  = w_grant_ld ? {24'h0, ld_wdata} : cpu_wdata;
    assign w_sel_store = w_grant_ld || cpu_we;

    // funct3[1] set covers LW plus the 011/110/111 encodings, all treated as word.
    assign w_sel_size  = w_grant_ld    ? SZ_BYTE :
                         cpu_funct3[1] ? SZ_WORD :
                         (cpu_funct3[0] ? SZ_HALF : SZ_BYTE);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign w_misalign = w_grant_cpu &&
                        (((w_sel_size == SZ_HALF) && w_sel_lo[0]) ||
                         ((w_sel_size == SZ_WORD) && (w_sel_lo != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_mask  = 4'b1111;
        w_wdata = w_sel_data;
        case (w_sel_size)
            SZ_BYTE: begin
                w_mask  = 4'b0001 << w_sel_lo;
                w_wdata = {4{w_sel_data[7:0]}};
            end
            SZ_HALF: begin
                w_mask  = w_sel_lo[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{w_sel_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_lo)
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            2'd3:    w_byte = mem_rdata[31:24];
            default: ;
        endcase
        w_half = r_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_size)
            SZ_BYTE: w_fmt = {{24{r_signed & w_byte[7]}}, w_byte};
            SZ_HALF: w_fmt = {{16{r_signed & w_half[15]}}, w_half};
            default: w_fmt = mem_rdata;
        endcase
    end

    // Memory data only arrives in RSP, so the formatted word bypasses the holding register there.
    assign cpu_rdata = r_rd_rsp ? w_fmt : r_cpu_rdata;

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_size      <= SZ_BYTE;
            r_signed    <= 1'b0;
            r_lo        <= 2'b00;
            r_rd_rsp    <= 1'b0;
            r_cpu_rdata <= 32'h0;
            ld_ack      <= 1'b0;
            cpu_ack     <= 1'b0;
            cpu_err     <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 4'b0000;
            mem_addr    <= '0;
            mem_wdata   <= 32'h0;
        end else begin
            ld_ack  <= 1'b0;
            cpu_ack <= 1'b0;
            cpu_err <= 1'b0;
            mem_en  <= 1'b0;
            mem_we  <= 4'b0000;
            case (r_state)
                IDLE: begin
                    if (w_grant_ld || w_grant_cpu) begin
                        r_size   <= w_sel_size;
                        r_signed <= ~cpu_funct3[2];
                        r_lo     <= w_sel_lo;
                        mem_addr <= w_sel_addr[ADDR_W-1:2];
                        if (w_misalign) begin
                            r_state <= RSP;
                            cpu_ack <= 1'b1;
                            cpu_err <= 1'b1;
                        end else if (w_sel_store) begin
                            r_state   <= WR;
                            mem_en    <= 1'b1;
                            mem_we    <= w_mask;
                            mem_wdata <= w_wdata;
                            ld_ack    <= w_grant_ld;
                            cpu_ack   <= w_grant_cpu;
                        end else begin
                            r_state <= RD;
                            mem_en  <= 1'b1;
                        end
                    end
                end
                WR: r_state <= IDLE;
                RD: begin
                    r_state  <= RSP;
                    cpu_ack  <= 1'b1;
                    r_rd_rsp <= 1'b1;
                end
                RSP: begin
                    if (r_rd_rsp) r_cpu_rdata <= w_fmt;
                    r_rd_rsp <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: directed loader/CPU traffic against a behavioural memory.
// Expected write strobes and CPU responses are queued at issue and checked by an independent monitor.
module tb_dmem_port_arbiter;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ld_req = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [7:0]        ld_wdata = 8'h0;
    logic              ld_ack;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [2:0]        cpu_funct3 = 3'd0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [31:0]       cpu_wdata = 32'h0;
    logic [31:0]       cpu_rdata;
    logic              cpu_ack;
    logic              cpu_err;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .LD_PRIORITY(1'b1)) dut (
        .clk(clk), .rst(rst),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_funct3(cpu_funct3), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]        we;
        logic [31:0]       wdata;
        logic [ADDR_W-3:0] addr;
    } wr_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_data;
    } rsp_t;

    wr_t  wr_q[$];
    rsp_t rsp_q[$];
    int   total = 0;
    int   bad = 0;
    int   rd_cnt = 0;
    logic [31:0] mem [0:(1<<(ADDR_W-2))-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial for (int i = 0; i < (1<<(ADDR_W-2)); i++) mem[i] = 32'h0;

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            if (mem_we == 4'b0000) mem_rdata <= mem[mem_addr];
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an ack or a write strobe.
    always @(negedge clk) begin
        if (rst) begin
            if (cpu_ack) begin
                if (rsp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_cpu_ack: got ack want none");
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    check("cpu_err", {31'h0, cpu_err}, {31'h0, e.err});
                    if (e.chk_data) check("cpu_rdata", cpu_rdata, e.rdata);
                end
            end
            if (mem_en && mem_we != 4'b0000) begin
                if (wr_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got we=%b want none", mem_we);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("mem_we", {28'h0, mem_we}, {28'h0, w.we});
                    check("mem_wdata", mem_wdata, w.wdata);
                    check("mem_addr", {22'h0, mem_addr}, {22'h0, w.addr});
                end
            end
            if (mem_en && mem_we == 4'b0000) rd_cnt++;
        end
    end

    task automatic ld_write(input logic [ADDR_W-1:0] a, input logic [7:0] d,
                            input logic [3:0] exp_we, input logic [31:0] exp_wd, input int exp_lat);
        int n;
        wr_t w;
        w.we = exp_we; w.wdata = exp_wd; w.addr = a[ADDR_W-1:2];
        @(posedge clk); #1;
        wr_q.push_back(w);
        ld_addr = a; ld_wdata = d; ld_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ld_ack && n < 20);
        check("ld_latency", 32'(n), 32'(exp_lat + 1));
        @(posedge clk); #1 ld_req = 1'b0;
    endtask

    task automatic cpu_access(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] a,
                              input logic [31:0] wd, input logic [3:0] exp_we, input logic [31:0] exp_wd,
                              input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int n;
        wr_t  w;
        rsp_t r;
        w.we = exp_we; w.wdata = exp_wd; w.addr = a[ADDR_W-1:2];
        r.rdata = exp_rd; r.err = exp_err; r.chk_data = !we;
        @(posedge clk); #1;
        if (we && !exp_err) wr_q.push_back(w);
        rsp_q.push_back(r);
        cpu_we = we; cpu_funct3 = f3; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!cpu_ack && n < 20);
        check("cpu_latency", 32'(n), 32'(exp_lat + 1));
        @(posedge clk); #1 cpu_req = 1'b0;
    endtask

    task automatic cpu_load(input logic [2:0] f3, input logic [ADDR_W-1:0] a,
                            input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        cpu_access(1'b0, f3, a, 32'h0, 4'b0000, 32'h0, exp_rd, exp_err, exp_lat);
    endtask

    initial begin
        int rd_before;
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_before;
        #23;
        check("rst_mem_en", {31'h0, mem_en}, 32'h0);
        check("rst_mem_we", {28'h0, mem_we}, 32'h0);
        check("rst_acks", {29'h0, ld_ack, cpu_ack, cpu_err}, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        @(posedge clk); #2 rst = 1'b1;

        ld_write(12'h000, 8'hFF, 4'b0001, 32'hFFFFFFFF, 1);
        ld_write(12'h001, 8'h00, 4'b0010, 32'h00000000, 1);
        cpu_load(3'b000, 12'h000, 32'hFFFFFFFF, 1'b0, 2);
        @(negedge clk);
        check("rdata_hold", cpu_rdata, 32'hFFFFFFFF);
        cpu_load(3'b000, 12'h001, 32'h00000000, 1'b0, 2);
        cpu_load(3'b100, 12'h000, 32'h000000FF, 1'b0, 2);

        ld_write(12'h004, 8'h44, 4'b0001, 32'h44444444, 1);
        ld_write(12'h005, 8'h55, 4'b0010, 32'h55555555, 1);
        ld_write(12'h006, 8'h66, 4'b0100, 32'h66666666, 1);
        ld_write(12'h007, 8'h77, 4'b1000, 32'h77777777, 1);

        cpu_access(1'b1, 3'b010, 12'h008, 32'h80017F80, 4'b1111, 32'h80017F80, 32'h0, 1'b0, 1);
        cpu_load(3'b001, 12'h008, 32'h00007F80, 1'b0, 2);
        cpu_load(3'b101, 12'h00A, 32'h00008001, 1'b0, 2);
        cpu_load(3'b001, 12'h00A, 32'hFFFF8001, 1'b0, 2);
        cpu_load(3'b000, 12'h009, 32'h0000007F, 1'b0, 2);
        cpu_load(3'b000, 12'h008, 32'hFFFFFF80, 1'b0, 2);

        cpu_access(1'b1, 3'b000, 12'h005, 32'hABCDEF12, 4'b0010, 32'h12121212, 32'h0, 1'b0, 1);
        cpu_load(3'b010, 12'h004, 32'h77661244, 1'b0, 2);

        cpu_access(1'b1, 3'b001, 12'h00E, 32'h1234BEEF, 4'b1100, 32'hBEEFBEEF, 32'h0, 1'b0, 1);
        cpu_load(3'b010, 12'h00C, 32'hBEEF0000, 1'b0, 2);
        cpu_load(3'b101, 12'h00E, 32'h0000BEEF, 1'b0, 2);
        cpu_load(3'b001, 12'h00E, 32'hFFFFBEEF, 1'b0, 2);

        cpu_load(3'b011, 12'h008, 32'h80017F80, 1'b0, 2);
        cpu_access(1'b1, 3'b111, 12'h010, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0, 1);
        cpu_load(3'b110, 12'h010, 32'hCAFEF00D, 1'b0, 2);

        cpu_load(3'b010, 12'h008, 32'h80017F80, 1'b0, 2);
        rd_before = rd_cnt;
`ifdef DMEM_MISALIGN_CHECK_EN
        cpu_load(3'b010, 12'h002, 32'h80017F80, 1'b1, 1);
        cpu_load(3'b001, 12'h009, 32'h80017F80, 1'b1, 1);
        check("misalign_no_mem_en", 32'(rd_cnt), 32'(rd_before));
`else
        cpu_load(3'b010, 12'h002, 32'h000000FF, 1'b0, 2);
        cpu_load(3'b001, 12'h009, 32'h00007F80, 1'b0, 2);
        check("aligned_down_reads", 32'(rd_cnt), 32'(rd_before + 2));
`endif

        fork
            ld_write(12'h014, 8'h5A, 4'b0001, 32'h5A5A5A5A, 1);
            cpu_load(3'b100, 12'h014, 32'h0000005A, 1'b0, 4);
        join

        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 12'h008; cpu_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rd_strobe", {27'h0, mem_en, mem_we}, {27'h0, 1'b1, 4'b0000});
        #1 rst = 1'b0;
        #1;
        check("midrst_mem_en", {31'h0, mem_en}, 32'h0);
        check("midrst_acks", {29'h0, ld_ack, cpu_ack, cpu_err}, 32'h0);
        check("midrst_cpu_rdata", cpu_rdata, 32'h0);
        cpu_req = 1'b0;
        @(posedge clk); #2 rst = 1'b1;

        cpu_access(1'b1, 3'b000, 12'h018, 32'h000000C3, 4'b0001, 32'hC3C3C3C3, 32'h0, 1'b0, 1);
        cpu_load(3'b010, 12'h018, 32'h000000C3, 1'b0, 2);

        repeat (4) @(negedge clk);
        check("rsp_q_empty", 32'(rsp_q.size()), 32'h0);
        check("wr_q_empty", 32'(wr_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
